// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM states, HALT opcode, default widths
// and the opcode[7:6] length encoding.
package fetch_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;

    localparam logic [7:0] OP_HALT = 8'hFF;

    // opcode[7:6] encodings; anything else is a 3-byte instruction
    localparam logic [1:0] ENC_1B = 2'b00;
    localparam logic [1:0] ENC_2B = 2'b01;

    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    typedef enum logic [2:0] {
        FETCH,
        LATCH,
        VALID,
        HALT,
        ERR
    } state_t;

endpackage

// File: rtl/instr_len_dec.sv
// Combinational opcode decode: instruction length (1..3) from the top two opcode
// bits, plus HALT detection. Zero latency, no flow control.
import fetch_pkg::*;

module instr_len_dec #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_opcode,
    output logic [1:0]        o_len,
    output logic              o_is_halt
);

    always_comb begin
        o_len = LEN_3;
        case (i_opcode[DATA_W-1 -: 2])
            ENC_1B:  o_len = LEN_1;
            ENC_2B:  o_len = LEN_2;
            default: o_len = LEN_3;
        endcase
        o_is_halt = (i_opcode == DATA_W'(OP_HALT));
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC + RAM address, instruction register, valid/ready to decoder; 2 edges
// FETCH->valid, fields held while !instr_ready. FETCH_PERF_CNT_EN adds instr_count.
import fetch_pkg::*;

module fetch_unit #(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_opcode,
    input  logic [DATA_W-1:0] ram_op1,
    input  logic [DATA_W-1:0] ram_op2,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_opcode,
    output logic [DATA_W-1:0] instr_op1,
    output logic [DATA_W-1:0] instr_op2,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [1:0]        instr_len,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              halted,
    output logic              fetch_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       instr_count
`endif
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_vld;
    logic [DATA_W-1:0]   r_opc;
    logic [DATA_W-1:0]   r_op1;
    logic [DATA_W-1:0]   r_op2;
    logic [ADDR_W-1:0]   r_ipc;
    logic [1:0]          r_len;
    logic                r_halted;
    logic                r_err;

    logic [1:0]          w_len;
    logic                w_is_halt;
    logic [ADDR_W:0]     w_last;
    logic                w_cross;
    logic                w_hs;

    instr_len_dec #(
        .DATA_W (DATA_W)
    ) u_len_dec (
        .i_opcode  (ram_opcode),
        .o_len     (w_len),
        .o_is_halt (w_is_halt)
    );

    // Address of the last byte, one bit wider so running past the top of memory is visible
    assign w_last  = {1'b0, r_pc} + (ADDR_W+1)'(w_len) - (ADDR_W+1)'(1);
    assign w_cross = (w_last > {1'b0, {ADDR_W{1'b1}}});
    assign w_hs    = r_vld && instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_vld    <= 1'b0;
            r_opc    <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_ipc    <= '0;
            r_len    <= '0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else if (jump_valid) begin
            // A pending instruction is dropped (or counted as consumed if handshaking now)
            r_state  <= FETCH;
            r_pc     <= jump_addr;
            r_vld    <= 1'b0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                FETCH: r_state <= LATCH;
                LATCH: begin
                    if (w_is_halt) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else if (w_cross) begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= VALID;
                        r_vld   <= 1'b1;
                        r_opc   <= ram_opcode;
                        r_op1   <= (w_len != LEN_1) ? ram_op1 : '0;
                        r_op2   <= (w_len == LEN_3) ? ram_op2 : '0;
                        r_ipc   <= r_pc;
                        r_len   <= w_len;
                    end
                end
                VALID: begin
                    if (w_hs) begin
                        r_state <= FETCH;
                        r_vld   <= 1'b0;
                        r_pc    <= r_pc + ADDR_W'(r_len);
                    end
                end
                HALT:    r_state <= HALT;
                ERR:     r_state <= ERR;
                default: r_state <= FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_hs && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign instr_count = r_count;
`endif

    assign ram_addr     = r_pc;
    assign ram_we       = 1'b0;
    assign instr_valid  = r_vld;
    assign instr_opcode = r_opc;
    assign instr_op1    = r_op1;
    assign instr_op2    = r_op2;
    assign instr_pc     = r_ipc;
    assign instr_len    = r_len;
    assign halted       = r_halted;
    assign fetch_err    = r_err;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the 64x8 program RAM. Holds the program counter, drives the RAM address, and captures the registered opcode/operand bytes into an instruction register. Presents each instruction to the decoder over a valid/ready handshake. Advances the PC by the instruction length, or redirects it on a jump request.

## Interface
- ADDR_W, 6, RAM address width; PC range 0..2^ADDR_W-1
- DATA_W, 8, byte width of opcode and operands
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  single system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ram_addr  out  ADDR_W  address to RAM (Addr); equals PC
- ram_we  out  1  RAM write enable; held 0 (fetch never writes)
- ram_opcode  in  DATA_W  RAM Opcode output (byte at addr)
- ram_op1  in  DATA_W  RAM Operando1 output (byte at addr+1)
- ram_op2  in  DATA_W  RAM Operando2 output (byte at addr+2)
- instr_valid  out  1  instruction register holds an unconsumed instruction
- instr_ready  in  1  decoder accepts instruction this cycle
- instr_opcode / instr_op1 / instr_op2  out  DATA_W each  captured bytes; unused operands forced to 0
- instr_pc  out  ADDR_W  address of the presented instruction
- instr_len  out  2  instruction length, 1..3
- jump_valid  in  1  redirect request, one-cycle pulse
- jump_addr  in  ADDR_W  redirect target
- halted  out  1  HALT opcode fetched; fetching stopped
- fetch_err  out  1  instruction crosses top of memory; fetching stopped

## Operation
- Length decode from opcode[7:6]: 00 -> 1 byte, 01 -> 2, 10/11 -> 3. Opcode 8'hFF is HALT, regardless of length.
- States: FETCH, LATCH, VALID, HALT, ERR.
- FETCH: ram_addr = PC. Next edge -> LATCH. The RAM samples Addr on that edge.
- LATCH: RAM outputs are valid. Next edge:
  - If opcode = HALT -> HALT, halted=1, instr_valid stays 0.
  - Else if PC + len - 1 > 2^ADDR_W-1 -> ERR, fetch_err=1.
  - Else capture the bytes into the instruction register, zeroing bytes beyond len. Set instr_pc and instr_len, set instr_valid=1, go to VALID.
- VALID: outputs held stable until instr_valid && instr_ready. On that edge: instr_valid=0, PC <= PC + len, go to FETCH.
- Jump, highest priority in every state: on an edge with jump_valid=1, PC <= jump_addr, instr_valid <= 0, halted <= 0, fetch_err <= 0, state <= FETCH. An in-flight fetch is discarded.
- Jump and handshake in the same cycle: the instruction counts as consumed, and the PC takes jump_addr, not PC+len.
- HALT and ERR are sticky until a jump or reset.
- PC arithmetic is modulo 2^ADDR_W. A 1-byte instruction at address 63 advances the PC to 0; this is legal.

## Timing
- Reset values: PC=RESET_PC, ram_addr=RESET_PC, ram_we=0, state=FETCH, instr_valid=0, instr_opcode/op1/op2=0, instr_pc=0, instr_len=0, halted=0, fetch_err=0.
- Reset asserted mid-operation clears everything immediately, asynchronously. Fetch restarts from RESET_PC on the first edge after release.
- Latency: instr_valid rises 2 edges after FETCH is entered (FETCH->LATCH->VALID).
- Back-to-back throughput with instr_ready held 1: one instruction per 3 cycles.
- ram_addr is registered; it changes only on clock edges. It must be stable for the whole FETCH cycle.
- Presented fields must not change while instr_valid=1 and instr_ready=0.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds output instr_count, 16 bits.
  - Reset to 0; increments on every valid/ready handshake; saturates at 16'hFFFF.
  - Not cleared by jump.
- Not defined: port and counter absent. All other behaviour identical.

## Structure
- Shared package fetch_pkg holds:
  - state enum (FETCH, LATCH, VALID, HALT, ERR)
  - OP_HALT = 8'hFF
  - ADDR_W/DATA_W defaults
  - length-encoding constants
- One combinational sub-module: instr_len_dec (opcode -> len, is_halt).
- FSM, PC and instruction register stay in fetch_unit.

## Test plan
- Reset release, RAM[0..2]=8'h85,8'h12,8'h34, ready=1 -> instr_valid at 2nd edge with opcode 85, op1 12, op2 34, pc 0, len 3; next fetch at ram_addr 3.
- RAM[3]=8'h41 (len 2), ready held 0 for 4 cycles -> outputs frozen with op2=0; after handshake, ram_addr=5.
- jump_valid with jump_addr=20 during LATCH -> captured bytes discarded, instr_valid stays 0, next instr_pc=20.
- RAM[10]=8'hFF -> halted=1, instr_valid stays 0, ram_addr frozen at 10; later jump to 0 clears halted and fetch resumes.
- 3-byte opcode 8'h80 at address 62 -> fetch_err=1, no instr_valid; 1-byte opcode 8'h00 at 63 -> PC wraps to 0.
- With FETCH_PERF_CNT_EN, 5 handshakes then rst pulse mid-FETCH -> instr_count 5 before reset, 0 and all outputs at reset values immediately after.
